// File: rtl/leg_recover_pkg.sv
// Shared constants for the leg-recover tile: widths, FSM state encoding and uio bit map.
package leg_recover_pkg;
  localparam int W  = 8;
  localparam int IW = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_SQR, S_SQX, S_SUB, S_ROOT, S_DONE
  } state_t;

  localparam int LOAD_R = 0;
  localparam int LOAD_X = 1;
  localparam int START  = 2;
  localparam int BUSY   = 3;
  localparam int DONE   = 4;
  localparam int ERR    = 5;

  localparam logic [7:0] UIO_OE = 8'b0011_1000;
endpackage

// File: rtl/leg_isqrt16.sv
// Bit-serial restoring square root of a 16-bit value; one result bit per clock, no multiplier.
module leg_isqrt16
  import leg_recover_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [15:0]   diff,
  output logic          busy,
  output logic          valid,
  output logic [W-1:0]  root
);

  logic [15:0]   r_rem;
  logic [W-1:0]  r_root;
  logic [IW-1:0] r_iter;
  logic          r_busy;
  logic          r_valid;

  logic [15:0]   w_rem_in;
  logic [W-1:0]  w_root_in;
  logic [IW-1:0] w_iter_in;
  logic [16:0]   w_delta;
  logic          w_take;
  logic [15:0]   w_rem_nx;
  logic [W-1:0]  w_root_nx;

  // r_rem tracks diff - root^2, so trial^2 <= diff reduces to
  // (root << (iter+1)) + (1 << 2*iter) <= r_rem. The go edge already resolves the top bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    w_rem_in  = r_rem;
    w_root_in = r_root;
    w_iter_in = r_iter;
    if (go) begin
      w_rem_in  = diff;
      w_root_in = '0;
      w_iter_in = IW'(W - 1);
    end
    w_delta   = ({9'b0, w_root_in} << ({1'b0, w_iter_in} + 4'd1))
              + (17'd1 << {w_iter_in, 1'b0});
    w_take    = (w_delta <= {1'b0, w_rem_in});
    w_rem_nx  = w_take ? (w_rem_in - w_delta[15:0]) : w_rem_in;
    w_root_nx = w_take ? (w_root_in | (8'd1 << w_iter_in)) : w_root_in;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; rst_n is only looked at on the clock edge.
    if (!rst_n) begin
      r_rem   <= '0;
      r_root  <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      r_valid <= 1'b0;
      if (go || r_busy) begin
        r_rem   <= w_rem_nx;
        r_root  <= w_root_nx;
        r_iter  <= w_iter_in - 3'd1;
        r_busy  <= (w_iter_in != '0);
        r_valid <= (w_iter_in == '0);
      end
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign root  = r_root;

endmodule

// File: rtl/tt_um_leg_recover.sv
// Recovers Y = floor(sqrt(R^2 - X^2)) from serially loaded R and X using one shared squarer.
module tt_um_leg_recover
  import leg_recover_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t       r_state;
  logic [W-1:0] r_r;
  logic [W-1:0] r_x;
  logic [W-1:0] r_uo;
  logic [15:0]  r_rsq;
  logic [15:0]  r_xsq;
  logic         r_busy;
  logic         r_done;
  logic         r_err;

  logic [W-1:0] w_mul_a;
  logic [15:0]  w_prod;
  logic         w_neg;
  logic [15:0]  w_diff;
  logic         w_go;
  logic         w_idle;
  logic         w_sq_busy;
  logic         w_sq_valid;
  logic [W-1:0] w_root;
  logic [7:0]   w_uio_out;
  logic         w_unused;

  assign w_mul_a = (r_state == S_SQR) ? r_r : r_x;
  assign w_prod  = {8'b0, w_mul_a} * {8'b0, w_mul_a};
  assign w_neg   = (r_xsq > r_rsq);
  assign w_diff  = r_rsq - r_xsq;
  assign w_go    = (r_state == S_SUB) && !w_neg;
  // DONE behaves as IDLE so a start during the done pulse is accepted back-to-back.
  assign w_idle  = (r_state == S_IDLE) || (r_state == S_DONE);

  leg_isqrt16 u_isqrt (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (w_go),
    .diff  (w_diff),
    .busy  (w_sq_busy),
    .valid (w_sq_valid),
    .root  (w_root)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_r     <= '0;
      r_x     <= '0;
      r_uo    <= '0;
      r_rsq   <= '0;
      r_xsq   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (uio_in[LOAD_R]) r_r <= ui_in;
          if (uio_in[LOAD_X]) r_x <= ui_in;
          r_state <= S_IDLE;
          if (uio_in[START]) begin
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= S_SQR;
          end
        end
        S_SQR: begin
          r_rsq   <= w_prod;
          r_state <= S_SQX;
        end
        S_SQX: begin
          r_xsq   <= w_prod;
          r_state <= S_SUB;
        end
        S_SUB: begin
          if (w_neg) begin
            r_err   <= 1'b1;
            r_uo    <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ROOT;
          end
        end
        S_ROOT: begin
          if (w_sq_valid) begin
            r_uo    <= w_root;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_uio_out       = 8'b0;
    w_uio_out[BUSY] = r_busy;
    w_uio_out[DONE] = r_done;
    w_uio_out[ERR]  = r_err;
  end

  assign uo_out   = r_uo;
  assign uio_out  = w_uio_out;
  assign uio_oe   = UIO_OE;
  assign w_unused = &{1'b0, ena, uio_in[7:3], w_sq_busy, w_idle};

endmodule

// File: tb/tb_tt_um_leg_recover.sv
// Randomized scoreboard bench for tt_um_leg_recover against an arithmetic reference model.
module tb_tt_um_leg_recover;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_leg_recover dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] y;
    logic       err;
    int         acc;
    int         dn;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_r = '0;
  logic [7:0] m_x = '0;
  logic [7:0] exp_uo = '0;
  logic       exp_err = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: largest y with y*y <= R^2 - X^2, error when X exceeds R.
  function automatic exp_t model(input logic [7:0] r, input logic [7:0] x);
    exp_t e;
    int   d;
    int   y;
    e.acc = 0;
    e.dn  = 0;
    if (x > r) begin
      e.y   = 8'd0;
      e.err = 1'b1;
    end else begin
      d = int'(r) * int'(r) - int'(x) * int'(x);
      y = 0;
      while ((y + 1) * (y + 1) <= d) y++;
      e.y   = 8'(y);
      e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit lr, input bit lx, input logic [7:0] v);
    ui_in  = v;
    uio_in = {6'b0, lx, lr};
    if (lr) m_r = v;
    if (lx) m_x = v;
    tick();
    uio_in = '0;
  endtask

  task automatic start_op(input bit lx_too, input logic [7:0] v);
    exp_t e;
    ui_in = v;
    if (lx_too) m_x = v;
    uio_in = {5'b0, 1'b1, lx_too, 1'b0};
    e     = model(m_r, m_x);
    e.acc = cyc + 1;
    e.dn  = e.acc + (e.err ? 3 : 11);
    sb.push_back(e);
    tick();
    uio_in = '0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (uio_out[4]) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("done_timeout", 16'(seen), 16'd1);
  endtask

  task automatic op(input logic [7:0] r, input logic [7:0] x);
    load(1, 0, r);
    load(0, 1, x);
    start_op(0, 8'd0);
    wait_done();
  endtask

  // Monitor: pops the scoreboard when done appears and tracks busy/err/uo every cycle.
  always @(negedge clk) begin
    bit   in_run;
    exp_t e;
    if (!rst_n) begin
      exp_uo  = '0;
      exp_err = 1'b0;
    end else begin
      in_run = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].dn);
      if (in_run) exp_err = 1'b0;
      check("busy", 16'(uio_out[3]), 16'(in_run));
      if (uio_out[4]) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 16'd1, 16'd0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 16'(cyc - e.acc), 16'(e.dn - e.acc));
          check("result", 16'(uo_out), 16'(e.y));
          check("err_at_done", 16'(uio_out[5]), 16'(e.err));
          exp_uo  = e.y;
          exp_err = e.err;
        end
      end else if (sb.size() > 0 && cyc >= sb[0].dn) begin
        check("late_done", 16'd0, 16'd1);
        void'(sb.pop_front());
      end
      check("err", 16'(uio_out[5]), 16'(exp_err));
      if (!in_run) check("uo_hold", 16'(uo_out), 16'(exp_uo));
    end
  end

  initial begin
    logic [7:0] r;
    logic [7:0] x;

    tick();
    tick();
    check("rst_uo", 16'(uo_out), 16'd0);
    check("rst_uio", 16'(uio_out), 16'd0);
    check("uio_oe", 16'(uio_oe), 16'h38);
    rst_n = 1'b1;
    tick();

    op(8'd5, 8'd3);
    op(8'd255, 8'd0);
    op(8'd255, 8'd255);
    op(8'd200, 8'd120);
    op(8'd10, 8'd7);
    op(8'd1, 8'd0);
    op(8'd3, 8'd5);
    // X loaded in the start cycle is used; err clears on this accepted start.
    start_op(1, 8'd0);
    wait_done();
    // Back-to-back: start while done is high, operands retained.
    start_op(0, 8'd0);
    wait_done();
    // Both strobes capture the same byte.
    load(1, 1, 8'd77);
    start_op(0, 8'd0);
    wait_done();

    // Strobes while busy must be ignored.
    load(1, 0, 8'd50);
    load(0, 1, 8'd30);
    start_op(0, 8'd0);
    tick();
    ui_in  = 8'd9;
    uio_in = 8'b0000_0111;
    tick();
    uio_in = '0;
    tick();
    uio_in = 8'b0000_0111;
    tick();
    uio_in = '0;
    wait_done();
    start_op(0, 8'd0);
    wait_done();

    for (int i = 0; i < 24; i++) begin
      r = 8'($urandom_range(255, 0));
      x = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 0)) : 8'($urandom_range(int'(r), 0));
      load(1, 0, r);
      if ($urandom_range(1, 0) == 1) begin
        start_op(1, x);
      end else begin
        load(0, 1, x);
        start_op(0, 8'd0);
      end
      wait_done();
      if ($urandom_range(2, 0) == 0) begin
        start_op(0, 8'd0);
        wait_done();
      end
    end

    // Reset in the middle of the root phase aborts the run and clears operands.
    op(8'd100, 8'd20);
    load(1, 0, 8'd200);
    load(0, 1, 8'd120);
    start_op(0, 8'd0);
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    sb.delete();
    m_r = '0;
    m_x = '0;
    tick();
    check("midrst_uo", 16'(uo_out), 16'd0);
    check("midrst_uio", 16'(uio_out), 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    start_op(0, 8'd0);
    wait_done();

    tick();
    tick();
    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
